// File: rtl/cu_pkg.sv
// Shared encodings for the computational_unit sequencer: operand codes,
// reg_en bit positions, opcode classes, FSM states and the decode record.
package cu_pkg;

    localparam logic [2:0] CODE_X0   = 3'd0;
    localparam logic [2:0] CODE_X1   = 3'd1;
    localparam logic [2:0] CODE_Y0   = 3'd2;
    localparam logic [2:0] CODE_Y1   = 3'd3;
    localparam logic [2:0] DST_OREG  = 3'd4;
    localparam logic [2:0] SRC_R     = 3'd4;
    localparam logic [2:0] CODE_M    = 3'd5;
    localparam logic [2:0] CODE_I    = 3'd6;
    localparam logic [2:0] CODE_DM   = 3'd7;

    localparam logic [3:0] SRC_DM    = 4'd7;
    localparam logic [3:0] SRC_IRNIB = 4'd8;
    localparam logic [3:0] SRC_PINS  = 4'd9;

    localparam int EN_X0   = 0;
    localparam int EN_X1   = 1;
    localparam int EN_Y0   = 2;
    localparam int EN_Y1   = 3;
    localparam int EN_R    = 4;
    localparam int EN_M    = 5;
    localparam int EN_I    = 6;
    localparam int EN_RSVD = 7;
    localparam int EN_OREG = 8;

    typedef enum logic [1:0] {
        CLS_LOAD = 2'd0,
        CLS_MOVE = 2'd1,
        CLS_ALU  = 2'd2
    } cls_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_DM_RD = 3'd2,
        S_DM_WB = 3'd3,
        S_INC   = 3'd4
    } state_e;

    typedef struct packed {
        logic [2:0] dst;
        logic [3:0] src;     // source_sel value used in the EXEC cycle
        cls_e       cls;
        logic       dm_rd;
        logic       dm_wr;
        logic [8:0] reg_en;
    } dec_t;

    // dst code 4 targets o_reg (bit 8), dst code 7 is memory with no register enable
    function automatic logic [8:0] dst_en(input logic [2:0] dst);
        logic [8:0] en;
        en = '0;
        case (dst)
            DST_OREG: en[EN_OREG] = 1'b1;
            CODE_DM:  en = '0;
            default:  en[dst] = 1'b1;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Pure combinational instruction decoder; also used by the trace monitor.
module cu_decode
    import cu_pkg::*;
(
    input  logic [7:0] instr_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o = '0;
        if (!instr_i[7]) begin
            dec_o.cls = CLS_LOAD;
            dec_o.dst = instr_i[6:4];
            dec_o.src = SRC_IRNIB;
        end else if (!instr_i[6]) begin
            dec_o.cls   = CLS_MOVE;
            dec_o.dst   = instr_i[5:3];
            // a self-move reads the external i_pins instead
            dec_o.src   = (instr_i[2:0] == instr_i[5:3]) ? SRC_PINS : {1'b0, instr_i[2:0]};
            dec_o.dm_rd = (instr_i[2:0] == CODE_DM) && (instr_i[5:3] != CODE_DM);
        end else begin
            dec_o.cls = CLS_ALU;
        end

        if (dec_o.cls == CLS_ALU) begin
            dec_o.reg_en[EN_R] = 1'b1;
        end else begin
            dec_o.dm_wr  = (dec_o.dst == CODE_DM);
            dec_o.reg_en = dst_en(dec_o.dst);
        end
    end

endmodule

// File: rtl/cu_sequencer.sv
// Decode/sequencing FSM for the 4-bit computational_unit; every control
// output is registered and pulses for exactly one cycle.
module cu_sequencer
    import cu_pkg::*;
#(
    parameter bit          DM_POST_INC = 1'b1,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic       clk_i,
    input  logic       sync_reset_n_i,
    input  logic [7:0] instr_i,
    input  logic       instr_valid_i,
    output logic       instr_ready_o,
    output logic [8:0] reg_en_o,
    output logic [3:0] source_sel_o,
    output logic       i_sel_o,
    output logic       x_sel_o,
    output logic       y_sel_o,
    output logic [3:0] nibble_ir_o,
    output logic       dm_re_o,
    output logic       dm_we_o,
    output logic       cu_sync_reset_o,
    output logic       busy_o
);

    localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

    state_e     state_q, state_d;
    logic [7:0] instr_q, instr_d;
    logic [1:0] cnt_q, cnt_d;
    logic [8:0] reg_en_q, reg_en_d;
    logic [3:0] source_sel_q, source_sel_d;
    logic [3:0] nibble_ir_q, nibble_ir_d;
    logic       i_sel_q, i_sel_d;
    logic       x_sel_q, x_sel_d;
    logic       y_sel_q, y_sel_d;
    logic       dm_re_q, dm_re_d;
    logic       dm_we_q, dm_we_d;
    logic       cu_rst_q;
    logic [7:0] dec_in;
    dec_t       dec;

    // in IDLE the outputs for the EXEC cycle are built from the incoming word
    assign dec_in = (state_q == S_IDLE) ? instr_i : instr_q;

    cu_decode u_decode (
        .instr_i (dec_in),
        .dec_o   (dec)
    );

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        cnt_d        = cnt_q;
        reg_en_d     = '0;
        source_sel_d = '0;
        nibble_ir_d  = '0;
        i_sel_d      = 1'b0;
        x_sel_d      = 1'b0;
        y_sel_d      = 1'b0;
        dm_re_d      = 1'b0;
        dm_we_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (instr_valid_i) begin
                    instr_d = instr_i;
                    if (dec.dm_rd) begin
                        state_d = S_DM_RD;
                        cnt_d   = LAT_M1;
                        dm_re_d = 1'b1;
                    end else begin
                        state_d      = S_EXEC;
                        reg_en_d     = dec.reg_en;
                        source_sel_d = dec.src;
                        dm_we_d      = dec.dm_wr;
                        if (dec.cls == CLS_ALU) begin
                            x_sel_d = dec_in[5];
                            y_sel_d = dec_in[4];
                        end
                        if (dec.cls != CLS_MOVE) nibble_ir_d = dec_in[3:0];
                    end
                end
            end
            S_EXEC: begin
                if (dec.dm_wr && DM_POST_INC) begin
                    state_d        = S_INC;
                    reg_en_d[EN_I] = 1'b1;
                    i_sel_d        = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DM_RD: begin
                if (cnt_q == 2'd0) begin
                    state_d      = S_DM_WB;
                    source_sel_d = SRC_DM;
                    reg_en_d     = dec.reg_en;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_DM_WB: begin
                // a read into i must not be overwritten by the increment
                if (DM_POST_INC && (dec.dst != CODE_I)) begin
                    state_d        = S_INC;
                    reg_en_d[EN_I] = 1'b1;
                    i_sel_d        = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        cu_rst_q <= ~sync_reset_n_i;
        if (!sync_reset_n_i) begin
            state_q      <= S_IDLE;
            instr_q      <= '0;
            cnt_q        <= '0;
            reg_en_q     <= '0;
            source_sel_q <= '0;
            nibble_ir_q  <= '0;
            i_sel_q      <= 1'b0;
            x_sel_q      <= 1'b0;
            y_sel_q      <= 1'b0;
            dm_re_q      <= 1'b0;
            dm_we_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            cnt_q        <= cnt_d;
            reg_en_q     <= reg_en_d;
            source_sel_q <= source_sel_d;
            nibble_ir_q  <= nibble_ir_d;
            i_sel_q      <= i_sel_d;
            x_sel_q      <= x_sel_d;
            y_sel_q      <= y_sel_d;
            dm_re_q      <= dm_re_d;
            dm_we_q      <= dm_we_d;
        end
    end

    assign instr_ready_o   = (state_q == S_IDLE);
    assign busy_o          = (state_q != S_IDLE);
    assign reg_en_o        = reg_en_q;
    assign source_sel_o    = source_sel_q;
    assign nibble_ir_o     = nibble_ir_q;
    assign i_sel_o         = i_sel_q;
    assign x_sel_o         = x_sel_q;
    assign y_sel_o         = y_sel_q;
    assign dm_re_o         = dm_re_q;
    assign dm_we_o         = dm_we_q;
    assign cu_sync_reset_o = cu_rst_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed bench for cu_sequencer: a per-instruction cycle-list model checked
// every cycle, plus hand-computed literal checks at key cycles.
module tb_cu_sequencer;

    localparam bit POST_INC = 1'b1;
    localparam int RD_LAT   = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] instr;
    logic       valid;
    logic       instr_ready_o, i_sel_o, x_sel_o, y_sel_o, dm_re_o, dm_we_o;
    logic       cu_sync_reset_o, busy_o;
    logic [8:0] reg_en_o;
    logic [3:0] source_sel_o, nibble_ir_o;

    always #5 clk = ~clk;

    cu_sequencer #(.DM_POST_INC(POST_INC), .RD_LAT(RD_LAT)) dut (
        .clk_i           (clk),
        .sync_reset_n_i  (rst_n),
        .instr_i         (instr),
        .instr_valid_i   (valid),
        .instr_ready_o   (instr_ready_o),
        .reg_en_o        (reg_en_o),
        .source_sel_o    (source_sel_o),
        .i_sel_o         (i_sel_o),
        .x_sel_o         (x_sel_o),
        .y_sel_o         (y_sel_o),
        .nibble_ir_o     (nibble_ir_o),
        .dm_re_o         (dm_re_o),
        .dm_we_o         (dm_we_o),
        .cu_sync_reset_o (cu_sync_reset_o),
        .busy_o          (busy_o)
    );

    typedef struct packed {
        logic [8:0] en;
        logic [3:0] sel;
        logic       isel, xs, ys;
        logic [3:0] nib;
        logic       re, we, busy, rdy;
        logic       nib_care, xy_care;
    } rec_t;

    int   tests = 0;
    int   fails = 0;
    rec_t pend[$];
    logic cu_exp = 1'b1;
    bit   started = 1'b0;
    bit   b2b = 1'b0;
    int   re_cnt = 0, we_cnt = 0;

    function automatic logic [8:0] en_of(input logic [2:0] d);
        if (d == 3'd7) return 9'h000;
        if (d == 3'd4) return 9'h100;
        return 9'h001 << d;
    endfunction

    function automatic rec_t busy_rec();
        rec_t r;
        r = '0;
        r.busy = 1'b1;
        return r;
    endfunction

    // Expected output for each cycle following the accept cycle.
    function automatic void expand(input logic [7:0] w);
        rec_t r;
        logic [2:0] dst, src;
        r = busy_rec();
        if (w[7:6] == 2'b11) begin
            r.en = 9'h010; r.xs = w[5]; r.ys = w[4]; r.nib = w[3:0];
            r.nib_care = 1'b1; r.xy_care = 1'b1;
            pend.push_back(r);
            return;
        end
        if (!w[7]) begin
            dst = w[6:4];
            r.sel = 4'd8; r.nib = w[3:0]; r.nib_care = 1'b1;
        end else begin
            dst = w[5:3];
            src = w[2:0];
            if (src == 3'd7 && dst != 3'd7) begin
                for (int k = 0; k < RD_LAT; k++) begin
                    r = busy_rec(); r.re = (k == 0); pend.push_back(r);
                end
                r = busy_rec(); r.sel = 4'd7; r.en = en_of(dst); pend.push_back(r);
                if (POST_INC && dst != 3'd6) begin
                    r = busy_rec(); r.en = 9'h040; r.isel = 1'b1; pend.push_back(r);
                end
                return;
            end
            r.sel = (src == dst) ? 4'd9 : {1'b0, src};
        end
        r.en = en_of(dst);
        r.we = (dst == 3'd7);
        pend.push_back(r);
        if (dst == 3'd7 && POST_INC) begin
            r = busy_rec(); r.en = 9'h040; r.isel = 1'b1; pend.push_back(r);
        end
    endfunction

    always @(posedge clk) begin
        cu_exp  <= !rst_n;
        started <= 1'b1;
        if (!rst_n) pend.delete();
        else if (pend.size() > 0) void'(pend.pop_front());
        else if (valid) expand(instr);
    end

    always @(negedge clk) begin
        rec_t e;
        logic ok;
        if (started) begin
            e = '0;
            e.rdy = 1'b1;
            if (pend.size() > 0) e = pend[0];
            ok = (reg_en_o === e.en) && (source_sel_o === e.sel) && (i_sel_o === e.isel) &&
                 (dm_re_o === e.re) && (dm_we_o === e.we) && (busy_o === e.busy) &&
                 (instr_ready_o === e.rdy) && (cu_sync_reset_o === cu_exp) &&
                 (!e.nib_care || nibble_ir_o === e.nib) &&
                 (!e.xy_care || (x_sel_o === e.xs && y_sel_o === e.ys));
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL cycle t=%0t got en=%h sel=%h isel=%b re=%b we=%b busy=%b rdy=%b nib=%h xy=%b%b cu=%b, exp en=%h sel=%h isel=%b re=%b we=%b busy=%b rdy=%b nib=%h xy=%b%b cu=%b",
                         $time, reg_en_o, source_sel_o, i_sel_o, dm_re_o, dm_we_o, busy_o, instr_ready_o,
                         nibble_ir_o, x_sel_o, y_sel_o, cu_sync_reset_o,
                         e.en, e.sel, e.isel, e.re, e.we, e.busy, e.rdy, e.nib, e.xs, e.ys, cu_exp);
            end
            if (b2b) begin
                re_cnt += int'(dm_re_o);
                we_cnt += int'(dm_we_o);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Present w until accepted; returns 1 time unit after the accept edge.
    task automatic send(input logic [7:0] w, input bit keep);
        int n;
        instr = w;
        valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!instr_ready_o && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready_o) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout instr=%h got ready=0 exp ready=1", w);
        end
        @(posedge clk);
        #1;
        if (!keep) valid = 1'b0;
    endtask

    logic [7:0] tbl [12] = '{8'hB8, 8'h7A, 8'hBF, 8'h4C, 8'hB0, 8'h00,
                             8'h3F, 8'h67, 8'h8C, 8'hC5, 8'hAE, 8'hE0};
    logic [7:0] bb  [6]  = '{8'h15, 8'hAF, 8'h7A, 8'hFB, 8'hB7, 8'hA2};

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        instr = 8'h00;
        @(posedge clk);
        @(negedge clk);
        chk("rst_cu", 32'(cu_sync_reset_o), 32'h1);
        chk("rst_en", 32'(reg_en_o), 32'h0);
        chk("rst_rdy", 32'(instr_ready_o), 32'h1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("cu_lag", 32'(cu_sync_reset_o), 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("cu_rel", 32'(cu_sync_reset_o), 32'h0);

        send(8'h15, 1'b0);
        @(negedge clk);
        chk("ld_en", 32'(reg_en_o), 32'h002);
        chk("ld_sel", 32'(source_sel_o), 32'h8);
        chk("ld_nib", 32'(nibble_ir_o), 32'h5);
        @(negedge clk);
        chk("ld_rdy", 32'(instr_ready_o), 32'h1);

        send(8'hA2, 1'b0);
        @(negedge clk);
        chk("mv_en", 32'(reg_en_o), 32'h100);
        chk("mv_sel", 32'(source_sel_o), 32'h2);
        send(8'h9B, 1'b0);
        @(negedge clk);
        chk("pins_sel", 32'(source_sel_o), 32'h9);
        chk("pins_en", 32'(reg_en_o), 32'h008);

        send(8'hFB, 1'b0);
        @(negedge clk);
        chk("alu", {reg_en_o, x_sel_o, y_sel_o, nibble_ir_o}, {9'h010, 1'b1, 1'b1, 4'hB});
        @(negedge clk);
        chk("alu_busy", 32'(busy_o), 32'h0);

        send(8'hAF, 1'b0);
        @(negedge clk);
        chk("rd_re", {dm_re_o, reg_en_o}, {1'b1, 9'h000});
        @(negedge clk);
        chk("rd_wb", {dm_re_o, source_sel_o, reg_en_o}, {1'b0, 4'h7, 9'h020});
        @(negedge clk);
        chk("rd_inc", {i_sel_o, reg_en_o}, {1'b1, 9'h040});
        @(negedge clk);
        chk("rd_rdy", 32'(instr_ready_o), 32'h1);

        send(8'hB7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rdi_wb", {source_sel_o, reg_en_o}, {4'h7, 9'h040});
        @(negedge clk);
        chk("rdi_noinc", {instr_ready_o, i_sel_o, reg_en_o}, {1'b1, 1'b0, 9'h000});

        send(8'hBF, 1'b0);
        @(negedge clk);
        chk("wr_pins", {dm_we_o, source_sel_o, reg_en_o}, {1'b1, 4'h9, 9'h000});
        @(negedge clk);
        chk("wr_inc", {dm_we_o, i_sel_o, reg_en_o}, {1'b0, 1'b1, 9'h040});

        foreach (tbl[i]) send(tbl[i], 1'b0);

        send(8'hAF, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_re", 32'(dm_re_o), 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("abort_out", {busy_o, source_sel_o, reg_en_o, i_sel_o}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_idle", {instr_ready_o, reg_en_o, i_sel_o}, {1'b1, 9'h000, 1'b0});

        b2b = 1'b1;
        foreach (bb[i]) send(bb[i], 1'b1);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        b2b = 1'b0;
        chk("b2b_re", 32'(re_cnt), 32'd2);
        chk("b2b_we", 32'(we_cnt), 32'd1);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
